radic_share_arb: RTL and testbench

// - Shares one 16-bit -> 8-bit integer square-root core among N_REQ requesters using round-robin arbitration.
// - Sequences the core's level handshake: START is held high until FIN, then released until FIN drops.
// - Returns each result to the granted requester, with a watchdog error path.
// - Sits between the acquisition/processing clients and the single square-root core instance.

---
 rtl/radic_share_arb_pkg.sv | 35 +++
 rtl/radic_share_arb_if.sv | 33 +++
 rtl/radic_share_arb_rr_pick.sv | 39 +++
 rtl/radic_share_arb.sv | 182 ++++++++++++++++++
 tb/tb_radic_share_arb.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/radic_share_arb_pkg.sv
// Shared types for the isqrt-core arbiter.
// The HIT state exists only when RADIC_CACHE_EN is defined.
package radic_arb_pkg;

   localparam int RADIC_X_W = 16;
   localparam int RADIC_R_W = 8;

   typedef logic [RADIC_X_W-1:0] x_t;
   typedef logic [RADIC_R_W-1:0] r_t;

   // Wide enough for any N_REQ up to 8
   typedef logic [2:0] gnt_t;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      RELEASE,
      DONE
`ifdef RADIC_CACHE_EN
      ,
      HIT
`endif
   } state_t;

   function automatic gnt_t rr_next(
      input gnt_t g,
      input int   n
   );
      if (int'(g) + 1 >= n)
         return '0;
      return g + 3'd1;
   endfunction

endpackage

// File: rtl/radic_share_arb_if.sv
// Requester-side bus of the arbiter.
// master = client side, slave = arbiter side.
interface radic_share_arb_if #(
   parameter int N_REQ = 4
);
   import radic_arb_pkg::*;

   logic [N_REQ-1:0]           REQ_VALID;
   logic [RADIC_X_W*N_REQ-1:0] REQ_X;
   logic [N_REQ-1:0]           REQ_READY;
   logic [N_REQ-1:0]           RES_VALID;
   r_t                         RES_DATA;
   logic                       RES_ERR;

   modport master (
      output REQ_VALID,
      output REQ_X,
      input  REQ_READY,
      input  RES_VALID,
      input  RES_DATA,
      input  RES_ERR
   );

   modport slave (
      input  REQ_VALID,
      input  REQ_X,
      output REQ_READY,
      output RES_VALID,
      output RES_DATA,
      output RES_ERR
   );

endinterface

// File: rtl/radic_share_arb_rr_pick.sv
// Combinational round-robin picker: first set request
// at or after ptr, wrapping modulo N_REQ.
module radic_rr_pick
   import radic_arb_pkg::*;
#(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0] req,
   input  gnt_t             ptr,
   output logic [N_REQ-1:0] gnt_oh,
   output gnt_t             gnt_idx,
   output logic             any
);

   logic [2*N_REQ-1:0] dbl;
   logic [N_REQ-1:0]   rot;
   logic [3:0]         sum;
   logic               hit;

   always_comb begin
      dbl = {req, req};
      // rotate so bit 0 is the requester at ptr
      rot = N_REQ'(dbl >> ptr);
      hit = 1'b0;
      sum = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!hit && rot[k]) begin
            hit = 1'b1;
            sum = {1'b0, ptr} + 4'(k);
         end
      end
      if (sum >= 4'(N_REQ))
         sum = sum - 4'(N_REQ);
      gnt_idx = gnt_t'(sum);
      gnt_oh  = hit ? (N_REQ'(1) << sum) : '0;
      any     = hit;
   end

endmodule

// File: rtl/radic_share_arb.sv
// Round-robin sharing of one 16->8 bit isqrt core.
// Define RADIC_CACHE_EN for a one-entry result cache.
module radic_share_arb
   import radic_arb_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int TIMEOUT_CYC = 1023
) (
   input  logic             CLK,
   input  logic             RESET,
   radic_share_arb_if.slave req_if,
   output logic             BUSY,
   output logic             SQ_START,
   output x_t               SQ_X,
   input  logic             SQ_FIN,
   input  r_t               SQ_COUNT
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] T_LAST =
      TW'(TIMEOUT_CYC - 1);

   state_t           state_q, state_d;
   gnt_t             gnt_q, gnt_d;
   gnt_t             ptr_q, ptr_d;
   gnt_t             pick_idx;
   x_t               x_q, x_d, x_sel;
   r_t               res_q, res_d;
   logic             err_q, err_d;
   logic [TW-1:0]    tmr_q, tmr_d;
   logic [N_REQ-1:0] pick_oh;
   logic [N_REQ-1:0] gnt_oh;
   logic             pick_any;
`ifdef RADIC_CACHE_EN
   logic             c_vld_q, c_vld_d;
   x_t               c_x_q, c_x_d;
   r_t               c_r_q, c_r_d;
`endif

   radic_rr_pick #(
      .N_REQ (N_REQ)
   ) u_pick (
      .req     (req_if.REQ_VALID),
      .ptr     (ptr_q),
      .gnt_oh  (pick_oh),
      .gnt_idx (pick_idx),
      .any     (pick_any)
   );

   always_comb begin
      x_sel = '0;
      for (int k = 0; k < N_REQ; k++)
         if (pick_oh[k])
            x_sel = req_if.REQ_X[RADIC_X_W*k +: RADIC_X_W];
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      ptr_d   = ptr_q;
      x_d     = x_q;
      res_d   = res_q;
      err_d   = err_q;
      tmr_d   = tmr_q;
`ifdef RADIC_CACHE_EN
      c_vld_d = c_vld_q;
      c_x_d   = c_x_q;
      c_r_d   = c_r_q;
`endif
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               gnt_d = pick_idx;
`ifdef RADIC_CACHE_EN
               if (c_vld_q && x_sel == c_x_q) begin
                  res_d   = c_r_q;
                  err_d   = 1'b0;
                  state_d = HIT;
               end else begin
                  x_d     = x_sel;
                  state_d = ISSUE;
               end
`else
               x_d     = x_sel;
               state_d = ISSUE;
`endif
            end
         end
         ISSUE: begin
            tmr_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (tmr_q != '1)
               tmr_d = tmr_q + 1'b1;
            // a finishing core wins over a same-cycle timeout
            if (SQ_FIN) begin
               res_d   = SQ_COUNT;
               err_d   = 1'b0;
               state_d = RELEASE;
            end else if (tmr_q == T_LAST) begin
               res_d   = '0;
               err_d   = 1'b1;
               state_d = RELEASE;
            end
         end
         RELEASE: begin
            if (!SQ_FIN)
               state_d = DONE;
         end
         DONE: begin
            ptr_d   = rr_next(gnt_q, N_REQ);
            state_d = IDLE;
`ifdef RADIC_CACHE_EN
            if (err_q) begin
               c_vld_d = 1'b0;
            end else begin
               c_vld_d = 1'b1;
               c_x_d   = x_q;
               c_r_d   = res_q;
            end
`endif
         end
`ifdef RADIC_CACHE_EN
         HIT: begin
            ptr_d   = rr_next(gnt_q, N_REQ);
            state_d = IDLE;
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         ptr_q   <= '0;
         x_q     <= '0;
         res_q   <= '0;
         err_q   <= 1'b0;
         tmr_q   <= '0;
`ifdef RADIC_CACHE_EN
         c_vld_q <= 1'b0;
         c_x_q   <= '0;
         c_r_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         ptr_q   <= ptr_d;
         x_q     <= x_d;
         res_q   <= res_d;
         err_q   <= err_d;
         tmr_q   <= tmr_d;
`ifdef RADIC_CACHE_EN
         c_vld_q <= c_vld_d;
         c_x_q   <= c_x_d;
         c_r_q   <= c_r_d;
`endif
      end
   end

   assign gnt_oh          = N_REQ'(1) << gnt_q;
   assign SQ_X            = x_q;
   assign req_if.RES_DATA = res_q;

   always_comb begin
      BUSY     = state_q != IDLE;
      SQ_START = state_q == ISSUE || state_q == WAIT;
      req_if.REQ_READY = (state_q == ISSUE) ? gnt_oh : '0;
      req_if.RES_VALID = (state_q == DONE) ? gnt_oh : '0;
      req_if.RES_ERR   = err_q && state_q == DONE;
`ifdef RADIC_CACHE_EN
      if (state_q == HIT) begin
         req_if.REQ_READY = gnt_oh;
         req_if.RES_VALID = gnt_oh;
      end
`endif
   end

endmodule

// File: tb/tb_radic_share_arb.sv
// Bench for radic_share_arb with a behavioural isqrt core.
// Cache checks depend on RADIC_CACHE_EN.
module tb_radic_share_arb;
   import radic_arb_pkg::*;

   localparam int N  = 4;
   localparam int TO = 1023;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic        BUSY, SQ_START, SQ_FIN;
   logic [15:0] SQ_X;
   logic [7:0]  SQ_COUNT;

   radic_share_arb_if #(.N_REQ(N)) bus ();

   radic_share_arb #(
      .N_REQ       (N),
      .TIMEOUT_CYC (TO)
   ) dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .req_if   (bus.slave),
      .BUSY     (BUSY),
      .SQ_START (SQ_START),
      .SQ_X     (SQ_X),
      .SQ_FIN   (SQ_FIN),
      .SQ_COUNT (SQ_COUNT)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;
   int mdl_ptr = 0;
   bit stuck = 1'b0;
   int lat_core = 4;

   int ob_g[$], ob_r[$], ob_d[$], ob_e[$];
   int ob_rc[$], ob_vc[$];
   int st_first, st_hi, multi;
   bit b_tmo;

   function automatic int isqrt(input int x);
      int r = 0;
      while ((r + 1) * (r + 1) <= x) r++;
      return r;
   endfunction

   function automatic int oh2idx(input logic [N-1:0] v);
      int r = -1;
      if ($countones(v) != 1) return -1;
      for (int k = 0; k < N; k++) if (v[k]) r = k;
      return r;
   endfunction

   function automatic logic [15:0] pick_x();
      case ($urandom_range(5))
         0: return 16'd0;
         1: return 16'hFFFF;
         2: return 16'd1;
         default: return 16'($urandom);
      endcase
   endfunction

   // Level-handshake core: FIN after a random delay, drops after START falls
   initial begin
      int cnt;
      SQ_FIN = 1'b0;
      SQ_COUNT = '0;
      cnt = 0;
      forever begin
         @(posedge CLK);
         #1;
         if (!RESET) begin
            SQ_FIN = 1'b0;
            cnt = 0;
         end else if (!SQ_FIN) begin
            if (SQ_START && !stuck) begin
               cnt++;
               if (cnt >= lat_core) begin
                  SQ_FIN = 1'b1;
                  SQ_COUNT = 8'(isqrt(int'(SQ_X)));
                  cnt = 0;
                  lat_core = $urandom_range(12, 2);
               end
            end else begin
               cnt = 0;
            end
         end else if (!SQ_START) begin
            SQ_FIN = 1'b0;
         end
      end
   end

   task automatic run_burst(
      input logic [N-1:0] mask,
      input bit hold,
      input int n_res,
      input int budget
   );
      int rd = 0;
      int rs = 0;
      int cyc = 0;
      ob_g.delete(); ob_r.delete(); ob_d.delete();
      ob_e.delete(); ob_rc.delete(); ob_vc.delete();
      st_first = -1; st_hi = 0; multi = 0;
      @(negedge CLK);
      bus.REQ_VALID = mask;
      while (rs < n_res && cyc < budget) begin
         @(negedge CLK);
         cyc++;
         if (SQ_START) begin
            if (st_first < 0) st_first = cyc;
            st_hi++;
         end
         if (bus.REQ_READY != '0) begin
            ob_g.push_back(oh2idx(bus.REQ_READY));
            ob_rc.push_back(cyc);
            rd++;
            if (hold && rd >= n_res) bus.REQ_VALID = '0;
            else if (!hold)
               bus.REQ_VALID = bus.REQ_VALID & ~bus.REQ_READY;
         end
         if (bus.RES_VALID != '0) begin
            if ($countones(bus.RES_VALID) > 1) multi++;
            ob_r.push_back(oh2idx(bus.RES_VALID));
            ob_d.push_back(int'(bus.RES_DATA));
            ob_e.push_back(int'(bus.RES_ERR));
            ob_vc.push_back(cyc);
            rs++;
         end
      end
      bus.REQ_VALID = '0;
      b_tmo = rs < n_res;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge CLK);
      checks++;
      if ({BUSY, SQ_START, SQ_X, bus.REQ_READY, bus.RES_VALID,
           bus.RES_DATA, bus.RES_ERR} !== '0) begin
         errors++;
         $display("FAIL reset_outs got busy=%b st=%b x=%h rdy=%b vld=%b d=%h e=%b want all 0",
                  BUSY, SQ_START, SQ_X, bus.REQ_READY, bus.RES_VALID,
                  bus.RES_DATA, bus.RES_ERR);
      end
      RESET = 1'b1;
      mdl_ptr = 0;
      @(negedge CLK);
   endtask

   task automatic test_single();
      int si[3] = '{1, 2, 3};
      int sx[3] = '{144, 0, 65535};
      int sr[3] = '{12, 0, 255};
      for (int t = 0; t < 3; t++) begin
         bus.REQ_X = '0;
         bus.REQ_X[16*si[t] +: 16] = 16'(sx[t]);
         run_burst(N'(1) << si[t], 1'b0, 1, 2000);
         checks++;
         if (b_tmo || ob_g.size() != 1 || ob_r.size() != 1) begin
            errors++;
            $display("FAIL single_count x=%0d got rdy=%0d res=%0d want 1/1",
                     sx[t], ob_g.size(), ob_r.size());
            continue;
         end
         checks++;
         if (ob_g[0] !== si[t] || ob_r[0] !== si[t]) begin
            errors++;
            $display("FAIL single_idx got rdy=%0d res=%0d want %0d",
                     ob_g[0], ob_r[0], si[t]);
         end
         checks++;
         if (ob_d[0] !== sr[t] || ob_e[0] !== 0) begin
            errors++;
            $display("FAIL single_data x=%0d got %0d err=%0d want %0d err=0",
                     sx[t], ob_d[0], ob_e[0], sr[t]);
         end
         mdl_ptr = (si[t] + 1) % N;
      end
   endtask

   task automatic test_all4();
      int xs[4] = '{100, 81, 64, 49};
      int ex;
      bus.REQ_X = {16'd49, 16'd64, 16'd81, 16'd100};
      run_burst(4'b1111, 1'b0, 4, 4000);
      checks++;
      if (b_tmo || ob_g.size() != 4 || ob_r.size() != 4) begin
         errors++;
         $display("FAIL all4_count got rdy=%0d res=%0d want 4/4",
                  ob_g.size(), ob_r.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            ex = (mdl_ptr + k) % N;
            checks++;
            if (ob_g[k] !== ex || ob_r[k] !== ex ||
                ob_d[k] !== isqrt(xs[ex])) begin
               errors++;
               $display("FAIL all4_seq%0d got g=%0d r=%0d d=%0d want %0d/%0d/%0d",
                        k, ob_g[k], ob_r[k], ob_d[k], ex, ex, isqrt(xs[ex]));
            end
         end
      end
      checks++;
      if (multi !== 0) begin
         errors++;
         $display("FAIL all4_onehot got %0d multi-bit pulses want 0", multi);
      end
      mdl_ptr = mdl_ptr % N;
   endtask

   task automatic test_fair();
      int p, e, j;
      bus.REQ_X = '0;
      bus.REQ_X[15:0]  = 16'd400;
      bus.REQ_X[47:32] = 16'd900;
      run_burst(4'b0101, 1'b1, 4, 4000);
      checks++;
      if (b_tmo || ob_g.size() != 4 || ob_r.size() != 4) begin
         errors++;
         $display("FAIL fair_count got rdy=%0d res=%0d want 4/4",
                  ob_g.size(), ob_r.size());
         return;
      end
      p = mdl_ptr;
      for (int k = 0; k < 4; k++) begin
         e = -1;
         for (int i = 0; i < N; i++) begin
            j = (p + i) % N;
            if (e < 0 && (j == 0 || j == 2)) e = j;
         end
         p = (e + 1) % N;
         checks++;
         if (ob_g[k] !== e || ob_r[k] !== e ||
             ob_d[k] !== (e == 0 ? 20 : 30)) begin
            errors++;
            $display("FAIL fair_seq%0d got g=%0d r=%0d d=%0d want g=%0d",
                     k, ob_g[k], ob_r[k], ob_d[k], e);
         end
      end
      mdl_ptr = p;
   endtask

   task automatic test_random();
      logic [N-1:0] pend, ev;
      logic [15:0]  xv [N];
      int g, gx, e, nres, cyc, j;
      pend = '0; g = -1; gx = 0; nres = 0; cyc = 0;
      for (int k = 0; k < N; k++) xv[k] = '0;
      while ((nres < 40 || g >= 0 || BUSY) && cyc < 20000) begin
         @(negedge CLK);
         cyc++;
         if (bus.REQ_READY != '0) begin
            e = -1;
            for (int k = 0; k < N; k++) begin
               j = (mdl_ptr + k) % N;
               if (e < 0 && pend[j]) e = j;
            end
            ev = (e >= 0) ? N'(1) << e : '0;
            checks++;
            if (bus.REQ_READY !== ev || g >= 0) begin
               errors++;
               $display("FAIL rand_grant got %b want %b", bus.REQ_READY, ev);
            end
            g = e;
            if (e >= 0) gx = int'(xv[e]);
            pend = pend & ~ev;
         end
         if (bus.RES_VALID != '0) begin
            ev = (g >= 0) ? N'(1) << g : '0;
            checks++;
            if (bus.RES_VALID !== ev || bus.RES_ERR !== 1'b0 ||
                bus.RES_DATA !== 8'(isqrt(gx))) begin
               errors++;
               $display("FAIL rand_result got v=%b d=%0d e=%b want v=%b d=%0d e=0",
                        bus.RES_VALID, bus.RES_DATA, bus.RES_ERR, ev, isqrt(gx));
            end
            if (g >= 0) mdl_ptr = (g + 1) % N;
            g = -1;
            nres++;
         end
         for (int k = 0; k < N; k++) begin
            if (nres < 40 && !pend[k] && $urandom_range(3) == 0) begin
               pend[k] = 1'b1;
               xv[k] = pick_x();
            end
         end
         if (nres >= 40) pend = '0;
         bus.REQ_VALID = pend;
         for (int k = 0; k < N; k++) bus.REQ_X[16*k +: 16] = xv[k];
      end
      bus.REQ_VALID = '0;
      checks++;
      if (cyc >= 20000) begin
         errors++;
         $display("FAIL rand_budget got %0d results want 40", nres);
      end
   endtask

   task automatic test_timeout();
      stuck = 1'b1;
      bus.REQ_X = '0;
      bus.REQ_X[15:0] = 16'd1234;
      run_burst(4'b0001, 1'b0, 1, 3000);
      checks++;
      if (b_tmo || ob_r.size() != 1) begin
         errors++;
         $display("FAIL tmo_count got res=%0d want 1", ob_r.size());
      end else begin
         checks++;
         if (ob_e[0] !== 1 || ob_d[0] !== 0 || ob_r[0] !== 0) begin
            errors++;
            $display("FAIL tmo_result got e=%0d d=%0d r=%0d want 1/0/0",
                     ob_e[0], ob_d[0], ob_r[0]);
         end
         // ISSUE plus TO wait cycles, then RELEASE and DONE
         checks++;
         if (st_hi !== TO + 1 || ob_vc[0] - st_first !== TO + 2) begin
            errors++;
            $display("FAIL tmo_timing got hi=%0d dt=%0d want %0d/%0d",
                     st_hi, ob_vc[0] - st_first, TO + 1, TO + 2);
         end
      end
      repeat (3) @(negedge CLK);
      checks++;
      if (SQ_START !== 1'b0 || BUSY !== 1'b0) begin
         errors++;
         $display("FAIL tmo_after got st=%b busy=%b want 0/0", SQ_START, BUSY);
      end
      stuck = 1'b0;
      mdl_ptr = 1;
   endtask

   task automatic test_cache();
      bus.REQ_X = '0;
      bus.REQ_X[63:48] = 16'd225;
      for (int t = 0; t < 2; t++) begin
         run_burst(4'b1000, 1'b0, 1, 2000);
         checks++;
         if (b_tmo || ob_r.size() != 1 || ob_g.size() != 1) begin
            errors++;
            $display("FAIL cache_count%0d got res=%0d want 1", t, ob_r.size());
            continue;
         end
         checks++;
         if (ob_d[0] !== 15 || ob_r[0] !== 3 || ob_e[0] !== 0) begin
            errors++;
            $display("FAIL cache_data%0d got d=%0d r=%0d want 15/3", t,
                     ob_d[0], ob_r[0]);
         end
      end
      if (ob_vc.size() == 1 && ob_rc.size() == 1) begin
`ifdef RADIC_CACHE_EN
         checks++;
         if (st_hi !== 0 || ob_vc[0] > 2 || ob_rc[0] !== ob_vc[0]) begin
            errors++;
            $display("FAIL cache_hit got st=%0d lat=%0d rdy@%0d want 0/<=2/%0d",
                     st_hi, ob_vc[0], ob_rc[0], ob_vc[0]);
         end
`else
         checks++;
         if (st_hi === 0) begin
            errors++;
            $display("FAIL cache_off got st=%0d want >0", st_hi);
         end
`endif
      end
      mdl_ptr = 0;
   endtask

   task automatic test_reset_mid();
      int cyc = 0;
      stuck = 1'b1;
      bus.REQ_X = '0;
      bus.REQ_X[31:16] = 16'd5000;
      @(negedge CLK);
      bus.REQ_VALID = 4'b0010;
      while (bus.REQ_READY == '0 && cyc < 20) begin
         @(negedge CLK);
         cyc++;
      end
      bus.REQ_VALID = '0;
      repeat (10) @(negedge CLK);
      checks++;
      if (SQ_START !== 1'b1 || BUSY !== 1'b1 || SQ_X !== 16'd5000) begin
         errors++;
         $display("FAIL rstmid_wait got st=%b busy=%b x=%0d want 1/1/5000",
                  SQ_START, BUSY, SQ_X);
      end
      #2 RESET = 1'b0;
      #1;
      checks++;
      if ({BUSY, SQ_START, SQ_X, bus.REQ_READY, bus.RES_VALID,
           bus.RES_DATA, bus.RES_ERR} !== '0) begin
         errors++;
         $display("FAIL rstmid_clear got busy=%b st=%b x=%h d=%h want all 0",
                  BUSY, SQ_START, SQ_X, bus.RES_DATA);
      end
      @(negedge CLK);
      RESET = 1'b1;
      stuck = 1'b0;
      mdl_ptr = 0;
      bus.REQ_X = '0;
      bus.REQ_X[47:32] = 16'd16;
      run_burst(4'b0100, 1'b0, 1, 2000);
      checks++;
      if (b_tmo || ob_r.size() != 1 || ob_d[0] !== 4 || ob_r[0] !== 2) begin
         errors++;
         $display("FAIL rstmid_after got n=%0d d=%0d want 1 result d=4",
                  ob_r.size(), ob_r.size() > 0 ? ob_d[0] : -1);
      end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.REQ_VALID = '0;
      bus.REQ_X = '0;
      test_reset();
      test_single();
      test_all4();
      test_fair();
      test_random();
      test_timeout();
      test_cache();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
